// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, reset constants, fetch FSM states
// and the IF/ID pipeline bundle used by the fetch stage.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  OP_HLT    = 4'hF;
  localparam logic [15:0] PC_RESET  = 16'h0000;

  typedef enum logic [1:0] {
    FETCH,
    DISCARD,
    HALTED
  } fetchState_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcPlus2;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:   NOP_INSTR,
    pcPlus2: 16'h0000,
    valid:   1'b0
  };

  function automatic logic isHlt(
    input logic [15:0] instr
  );
    return instr[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Ports: clk, rst_n (sync, active-low),
// hold (keep contents), bubble (load NOP bubble), d (next bundle), q.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= IF_ID_BUBBLE;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= IF_ID_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC, redirect/discard/halt FSM, feeds IF/ID register.
// Ports: clk, rst_n, stall, branch_taken/target, imem_valid/instr in;
// pc_out, imem_req, instr_FD, pc_plus2_FD, valid_FD, halted,
// stall_cycles out. Macro FETCH_PERF_EN enables the stall counter.
module fetch_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        imem_valid,
  input  logic [15:0] imem_instr,
  output logic [15:0] pc_out,
  output logic        imem_req,
  output logic [15:0] instr_FD,
  output logic [15:0] pc_plus2_FD,
  output logic        valid_FD,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  fetchState_t state;
  fetchState_t stateNext;

  logic [15:0] pc;
  logic [15:0] pcNext;
  logic [15:0] pcPlus2;
  logic        imemReq;
  logic        haltedQ;

  logic   doBranch;
  logic   doStall;
  logic   doAccept;
  logic   doBubble;
  logic   ifHold;
  logic   ifBubble;
  if_id_t ifIdIn;
  if_id_t ifIdQ;

  // Modulo-2^16 increment; wrap is silent.
  assign pcPlus2 = pc + 16'd2;

  // One-hot per-cycle action: branch > stall > memory.
  assign doBranch = branch_taken;
  assign doStall  = !branch_taken && stall;
  assign doAccept = !branch_taken && !stall &&
                    (state == FETCH) && imem_valid;
  assign doBubble = !doBranch && !doStall && !doAccept;

  assign ifIdIn = '{
    instr:   imem_instr,
    pcPlus2: pcPlus2,
    valid:   1'b1
  };

  always_comb begin
    ifHold   = 1'b0;
    ifBubble = 1'b1;
    unique case (1'b1)
      doBranch: ifBubble = 1'b1;
      doStall:  ifHold   = 1'b1;
      doAccept: ifBubble = 1'b0;
      doBubble: ifBubble = 1'b1;
      default:  ifBubble = 1'b1;
    endcase
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    unique case (state)
      FETCH: begin
        if (doBranch) begin
          pcNext = branch_target;
          // Request for old PC still outstanding.
          if (!imem_valid) stateNext = DISCARD;
        end else if (doAccept) begin
          if (isHlt(imem_instr)) stateNext = HALTED;
          else pcNext = pcPlus2;
        end
      end
      DISCARD: begin
        if (doBranch) begin
          pcNext = branch_target;
        end else if (imem_valid) begin
          // Stale word arrives and is dropped even under stall.
          stateNext = FETCH;
        end
      end
      HALTED: begin
        if (doBranch) begin
          pcNext    = branch_target;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= PC_RESET;
      imemReq <= 1'b0;
      haltedQ <= 1'b0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      imemReq <= (stateNext == FETCH);
      haltedQ <= (stateNext == HALTED);
    end
  end

  if_id_reg uIfId (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (ifHold),
    .bubble (ifBubble),
    .d      (ifIdIn),
    .q      (ifIdQ)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt <= 16'h0000;
    end else if (stall && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign stall_cycles = stallCnt;
`else
  assign stall_cycles = 16'h0000;
`endif

  assign pc_out      = pc;
  assign imem_req    = imemReq;
  assign instr_FD    = ifIdQ.instr;
  assign pc_plus2_FD = ifIdQ.pcPlus2;
  assign valid_FD    = ifIdQ.valid;
  assign halted      = haltedQ;

endmodule
